// File: rtl/fetch_module_if.sv
// rtl/fetch_module_if.sv - IF/ID, redirect, hazard/debug and instruction-memory bundle for the fetch stage
interface fetch_module_if #(
    parameter int NB_BITS = 32,
    parameter int NB_JMP  = 28,
    parameter int NB_ADDR = 10
);
    logic                i_pc_src;
    logic                i_pc_beq;
    logic [NB_BITS-1:0]  i_brh_addr;
    logic [NB_JMP-1:0]   i_jmp_addr;
    logic                i_stall;
    logic                i_step_mode;
    logic                i_step;
    logic [NB_BITS-1:0]  i_imem_data;
    logic [NB_ADDR-1:0]  o_imem_addr;
    logic                o_imem_en;
    logic [NB_BITS-1:0]  o_if_id_pc;
    logic [NB_BITS-1:0]  o_if_id_instr;
    logic                o_valid;
    logic                o_halt;

    modport master (
        input  i_pc_src, i_pc_beq, i_brh_addr, i_jmp_addr,
        input  i_stall, i_step_mode, i_step, i_imem_data,
        output o_imem_addr, o_imem_en, o_if_id_pc, o_if_id_instr, o_valid, o_halt
    );

    modport slave (
        output i_pc_src, i_pc_beq, i_brh_addr, i_jmp_addr,
        output i_stall, i_step_mode, i_step, i_imem_data,
        input  o_imem_addr, o_imem_en, o_if_id_pc, o_if_id_instr, o_valid, o_halt
    );
endinterface

// File: rtl/fetch_module.sv
// rtl/fetch_module.sv - MIPS instruction-fetch stage with stall, single-step, redirect and HALT
module fetch_module #(
    parameter int                  NB_BITS = 32,
    parameter int                  NB_JMP  = 28,
    parameter int                  NB_ADDR = 10,
    parameter logic [NB_BITS-1:0]  HALT_OP = 32'hFFFF_FFFF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_module_if.master bus
);
    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    localparam logic [NB_BITS-1:0] PC_INC    = {{(NB_BITS-3){1'b0}}, 3'b100};
    localparam logic [NB_BITS-1:0] ALIGN_MSK = {{(NB_BITS-2){1'b1}}, 2'b00};

    logic [0:0]         state_q, state_d;
    logic [NB_BITS-1:0] pc_q, pc_d;
    logic [NB_BITS-1:0] if_id_pc_q, if_id_pc_d;
    logic               valid_q, valid_d;
    logic               imem_en;
    logic               advance;
    logic               redirect;
    logic               halt_hit;
    logic [NB_BITS-1:0] instr;
    logic [NB_BITS-1:0] target;
    logic [NB_BITS-1:0] pc_inc;

    assign instr    = valid_q ? bus.i_imem_data : '0;
    assign advance  = ~bus.i_stall & (~bus.i_step_mode | bus.i_step);
    assign redirect = bus.i_pc_src & valid_q;
    assign halt_hit = valid_q & (instr == HALT_OP) & advance;
    assign pc_inc   = pc_q + PC_INC;
    // Jumps keep the region bits of the jump's own PC+4; branches are word-aligned by masking.
    assign target   = bus.i_pc_beq ? (bus.i_brh_addr & ALIGN_MSK)
                                   : {if_id_pc_q[NB_BITS-1:NB_JMP], bus.i_jmp_addr};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_id_pc_d = if_id_pc_q;
        valid_d    = valid_q;
        imem_en    = 1'b0;
        if (state_q == S_HALT) begin
            valid_d = 1'b0;
        end else if (halt_hit) begin
            state_d = S_HALT;
            valid_d = 1'b0;
        end else if (bus.i_stall) begin
            valid_d = valid_q;
        end else if (advance) begin
            imem_en    = 1'b1;
            pc_d       = redirect ? target : pc_inc;
            if_id_pc_d = pc_inc;
            valid_d    = ~redirect;
        end else begin
            // Step mode waiting for a pulse: bubble now, replay pc_q on the next step.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= S_RUN;
            pc_q       <= '0;
            if_id_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_id_pc_q <= if_id_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.o_imem_addr   = pc_q[NB_ADDR+1:2];
    assign bus.o_imem_en     = imem_en;
    assign bus.o_if_id_pc    = if_id_pc_q;
    assign bus.o_if_id_instr = instr;
    assign bus.o_valid       = valid_q;
    assign bus.o_halt        = (state_q == S_HALT);
endmodule
